// File: rtl/udp_payload_word_packer.sv
// ---------------------------------------------------------------------------
// udp_payload_word_packer
//
// Packs a byte-serial UDP payload stream into 64-bit words with byte enables
// for the BATS parser input. One datagram is one Sequenced Unit.
//   - Every datagram starts in lane 0.
//   - The tail of a datagram is flushed as a partial word.
//   - Datagrams longer than MAX_DGRAM_BYTES are truncated; the excess bytes
//     are accepted and discarded.
//
// Parameters
//   MAX_DGRAM_BYTES  payload bytes forwarded per datagram
//   CNT_W            width of the statistics counters
//
// Ports
//   Clk40            clock for all logic
//   reset_n          synchronous active-low reset
//   s_byte/s_valid/s_last/s_ready
//                    byte stream in (transfer = s_valid & s_ready)
//   m_bytes          packed word; byte k of the word is on [63-8k -: 8]
//   m_byte_enables   bit 7-k set = lane k valid
//   m_data_valid     output word valid (transfer = m_data_valid & m_ready)
//   m_ready          parser ready for input
//   dgram_count      datagrams completed (s_last accepted), wraps
//   trunc_count      datagrams truncated, wraps
//   trunc_pulse      one-cycle pulse when a truncation starts
// ---------------------------------------------------------------------------
module udp_payload_word_packer #(
    parameter int MAX_DGRAM_BYTES = 1500,
    parameter int CNT_W           = 32
) (
    input  logic             Clk40,
    input  logic             reset_n,
    input  logic [7:0]       s_byte,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [63:0]      m_bytes,
    output logic [7:0]       m_byte_enables,
    output logic             m_data_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] dgram_count,
    output logic [CNT_W-1:0] trunc_count,
    output logic             trunc_pulse
);

    localparam int BCNT_W = $clog2(MAX_DGRAM_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP
    } state_t;

    state_t              state;
    logic [63:0]         acc;
    logic [3:0]          fill;
    logic                acc_done;
    logic [BCNT_W-1:0]   bcnt;

    logic                out_free;
    logic                pending;
    logic                load_out;
    logic                accept;
    logic                take_byte;
    logic [BCNT_W-1:0]   bcnt_inc;
    logic                hit_max;
    logic [63:0]         acc_wr;
    logic [3:0]          base_fill;
    logic [3:0]          fill_wr;

    // A completed word may leave the accumulator when the output register is
    // empty or draining this cycle. Because the accumulator is vacated on that
    // same edge, a new byte can be written into lane 0 concurrently, which
    // keeps the 1-word-per-8-cycles rate. In DROP the bytes never touch the
    // accumulator, so they are accepted even while a word is pending.
    always_comb begin
        out_free  = !m_data_valid || m_ready;
        pending   = acc_done && !out_free;
        load_out  = acc_done && out_free;
        s_ready   = reset_n && ((state == DROP) || !pending);
        accept    = s_valid && s_ready;
        take_byte = accept && (state != DROP);
        bcnt_inc  = bcnt + 1'b1;
        hit_max   = take_byte && !s_last && (bcnt_inc == BCNT_W'(MAX_DGRAM_BYTES));
        base_fill = load_out ? 4'd0 : fill;
        acc_wr    = load_out ? 64'd0 : acc;
        for (int k = 0; k < 8; k++) begin
            if (base_fill == 4'(k)) begin
                acc_wr[63-8*k -: 8] = s_byte;
            end
        end
        fill_wr   = base_fill + 4'd1;
    end

    always_ff @(posedge Clk40) begin
        if (!reset_n) begin
            state          <= IDLE;
            acc            <= '0;
            fill           <= '0;
            acc_done       <= 1'b0;
            bcnt           <= '0;
            m_bytes        <= '0;
            m_byte_enables <= '0;
            m_data_valid   <= 1'b0;
            dgram_count    <= '0;
            trunc_count    <= '0;
            trunc_pulse    <= 1'b0;
        end else begin
            trunc_pulse <= hit_max;

            // A word completes on the 8th lane, on s_last, or on truncation.
            if (take_byte) begin
                acc      <= acc_wr;
                fill     <= fill_wr;
                acc_done <= (fill_wr == 4'd8) || s_last || hit_max;
            end else if (load_out) begin
                acc      <= '0;
                fill     <= '0;
                acc_done <= 1'b0;
            end

            // Unwritten lanes of acc are always zero, so a partial word
            // carries zeros in its unused lanes.
            if (load_out) begin
                m_bytes        <= acc;
                m_byte_enables <= 8'hFF << (4'd8 - fill);
                m_data_valid   <= 1'b1;
            end else if (m_data_valid && m_ready) begin
                m_bytes        <= '0;
                m_byte_enables <= '0;
                m_data_valid   <= 1'b0;
            end

            if (accept && s_last) begin
                dgram_count <= dgram_count + 1'b1;
            end
            if (hit_max) begin
                trunc_count <= trunc_count + 1'b1;
            end

            // s_last on the MAX-th byte wins over truncation.
            case (state)
                IDLE, FILL: begin
                    if (take_byte) begin
                        if (s_last) begin
                            state <= IDLE;
                            bcnt  <= '0;
                        end else if (hit_max) begin
                            state <= DROP;
                            bcnt  <= '0;
                        end else begin
                            state <= FILL;
                            bcnt  <= bcnt_inc;
                        end
                    end
                end
                DROP: begin
                    if (accept && s_last) begin
                        state <= IDLE;
                        bcnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    bcnt  <= '0;
                end
            endcase
        end
    end

endmodule
